// File: rtl/dm_cache_pkg.sv
// Shared types and helpers for the direct-mapped cache controller:
// FSM state encoding, word-address field slicing and a saturating increment.
package dm_cache_pkg;

    localparam int unsigned FIELD_W = 64;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        FILL_REQ,
        FILL,
        WR_MEM,
        RESP
    } state_e;

    function automatic logic [FIELD_W-1:0] addr_field(
        input logic [FIELD_W-1:0] addr,
        input int unsigned        lsb,
        input int unsigned        width
    );
        logic [FIELD_W-1:0] mask;
        mask = (width >= FIELD_W) ? '1 : ((FIELD_W'(1) << width) - FIELD_W'(1));
        return (addr >> lsb) & mask;
    endfunction

    function automatic logic [FIELD_W-1:0] addr_offset(
        input logic [FIELD_W-1:0] addr,
        input int unsigned        offset_w
    );
        return addr_field(addr, 0, offset_w);
    endfunction

    function automatic logic [FIELD_W-1:0] addr_index(
        input logic [FIELD_W-1:0] addr,
        input int unsigned        index_w,
        input int unsigned        offset_w
    );
        return addr_field(addr, offset_w, index_w);
    endfunction

    function automatic logic [FIELD_W-1:0] addr_tag(
        input logic [FIELD_W-1:0] addr,
        input int unsigned        addr_w,
        input int unsigned        index_w,
        input int unsigned        offset_w
    );
        return addr_field(addr, index_w + offset_w, addr_w - index_w - offset_w);
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        return (value == '1) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/dm_cache_array.sv
// Tag and data storage for the cache: asynchronous read of one tag and one
// word, synchronous single-word write and a separate line-tag write.
module dm_cache_array
    import dm_cache_pkg::*;
#(
    parameter int unsigned INDEX_W  = 8,
    parameter int unsigned OFFSET_W = 4,
    parameter int unsigned TAG_W    = 20,
    parameter int unsigned DATA_W   = 32
) (
    input  logic                clk,
    input  logic [INDEX_W-1:0]  i_rd_index,
    input  logic [OFFSET_W-1:0] i_rd_offset,
    output logic [TAG_W-1:0]    o_rd_tag,
    output logic [DATA_W-1:0]   o_rd_data,
    input  logic                i_wr_en,
    input  logic [INDEX_W-1:0]  i_wr_index,
    input  logic [OFFSET_W-1:0] i_wr_offset,
    input  logic [DATA_W-1:0]   i_wr_data,
    input  logic                i_tag_wr_en,
    input  logic [INDEX_W-1:0]  i_tag_index,
    input  logic [TAG_W-1:0]    i_tag_data
);

    localparam int unsigned LINES = 1 << INDEX_W;
    localparam int unsigned WORDS = 1 << (INDEX_W + OFFSET_W);

    logic [TAG_W-1:0]  r_tag  [LINES];
    logic [DATA_W-1:0] r_data [WORDS];

    logic [INDEX_W+OFFSET_W-1:0] w_rd_word;
    logic [INDEX_W+OFFSET_W-1:0] w_wr_word;

    assign w_rd_word = {i_rd_index, i_rd_offset};
    assign w_wr_word = {i_wr_index, i_wr_offset};

    assign o_rd_tag  = r_tag[i_rd_index];
    assign o_rd_data = r_data[w_rd_word];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_data[w_wr_word] <= i_wr_data;
        end
        if (i_tag_wr_en) begin
            r_tag[i_tag_index] <= i_tag_data;
        end
    end

endmodule

// File: rtl/dm_cache_ctrl.sv
// Direct-mapped, write-through, write-no-allocate cache controller serving one
// CPU request at a time; line refills are read in order from the memory port.
module dm_cache_ctrl
    import dm_cache_pkg::*;
#(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned INDEX_W  = 8,
    parameter int unsigned OFFSET_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_hit,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_write,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [DATA_W-1:0] mem_req_wdata,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_resp_rdata,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count
);

    localparam int unsigned TAG_W = ADDR_W - INDEX_W - OFFSET_W;
    localparam int unsigned LINES = 1 << INDEX_W;

    state_e              r_state;
    logic                r_req_ready;
    logic                r_req_write;
    logic [ADDR_W-1:0]   r_req_addr;
    logic [DATA_W-1:0]   r_req_wdata;
    logic [LINES-1:0]    r_valid;
    logic [OFFSET_W-1:0] r_beat_cnt;
    logic                r_resp_valid;
    logic [DATA_W-1:0]   r_resp_rdata;
    logic                r_resp_hit;
    logic                r_mem_req_valid;
    logic                r_mem_req_write;
    logic [ADDR_W-1:0]   r_mem_req_addr;
    logic [DATA_W-1:0]   r_mem_req_wdata;
    logic [31:0]         r_hit_count;
    logic [31:0]         r_miss_count;

    logic [TAG_W-1:0]    w_tag;
    logic [INDEX_W-1:0]  w_index;
    logic [OFFSET_W-1:0] w_offset;
    logic [TAG_W-1:0]    w_rd_tag;
    logic [DATA_W-1:0]   w_rd_data;
    logic                w_hit;
    logic                w_last_beat;
    logic                w_wr_en;
    logic [OFFSET_W-1:0] w_wr_offset;
    logic [DATA_W-1:0]   w_wr_data;
    logic                w_tag_wr_en;

    assign w_tag    = TAG_W'(addr_tag(FIELD_W'(r_req_addr), ADDR_W, INDEX_W, OFFSET_W));
    assign w_index  = INDEX_W'(addr_index(FIELD_W'(r_req_addr), INDEX_W, OFFSET_W));
    assign w_offset = OFFSET_W'(addr_offset(FIELD_W'(r_req_addr), OFFSET_W));

    assign w_hit       = r_valid[w_index] && (w_rd_tag == w_tag);
    assign w_last_beat = (r_beat_cnt == '1);

    // Single write port shared by store hits (LOOKUP) and refill beats (FILL).
    always_comb begin
        w_wr_en     = 1'b0;
        w_wr_offset = w_offset;
        w_wr_data   = r_req_wdata;
        w_tag_wr_en = 1'b0;
        case (r_state)
            LOOKUP: begin
                w_wr_en = r_req_write && w_hit;
            end
            FILL: begin
                if (mem_resp_valid) begin
                    w_wr_en     = 1'b1;
                    w_wr_offset = r_beat_cnt;
                    w_wr_data   = mem_resp_rdata;
                    w_tag_wr_en = w_last_beat;
                end
            end
            default: ;
        endcase
    end

    dm_cache_array #(
        .INDEX_W  (INDEX_W),
        .OFFSET_W (OFFSET_W),
        .TAG_W    (TAG_W),
        .DATA_W   (DATA_W)
    ) u_array (
        .clk         (clk),
        .i_rd_index  (w_index),
        .i_rd_offset (w_offset),
        .o_rd_tag    (w_rd_tag),
        .o_rd_data   (w_rd_data),
        .i_wr_en     (w_wr_en),
        .i_wr_index  (w_index),
        .i_wr_offset (w_wr_offset),
        .i_wr_data   (w_wr_data),
        .i_tag_wr_en (w_tag_wr_en),
        .i_tag_index (w_index),
        .i_tag_data  (w_tag)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= IDLE;
            r_req_ready     <= 1'b1;
            r_req_write     <= 1'b0;
            r_req_addr      <= '0;
            r_req_wdata     <= '0;
            r_valid         <= '0;
            r_beat_cnt      <= '0;
            r_resp_valid    <= 1'b0;
            r_resp_rdata    <= '0;
            r_resp_hit      <= 1'b0;
            r_mem_req_valid <= 1'b0;
            r_mem_req_write <= 1'b0;
            r_mem_req_addr  <= '0;
            r_mem_req_wdata <= '0;
            r_hit_count     <= '0;
            r_miss_count    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_req_write <= req_write;
                        r_req_addr  <= req_addr;
                        r_req_wdata <= req_wdata;
                        r_req_ready <= 1'b0;
                        r_state     <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    r_resp_hit <= w_hit;
                    if (w_hit) begin
                        r_hit_count <= sat_inc(r_hit_count);
                    end else begin
                        r_miss_count <= sat_inc(r_miss_count);
                    end
                    if (r_req_write) begin
                        r_resp_rdata    <= '0;
                        r_mem_req_valid <= 1'b1;
                        r_mem_req_write <= 1'b1;
                        r_mem_req_addr  <= r_req_addr;
                        r_mem_req_wdata <= r_req_wdata;
                        r_state         <= WR_MEM;
                    end else if (w_hit) begin
                        r_resp_rdata <= w_rd_data;
                        r_resp_valid <= 1'b1;
                        r_state      <= RESP;
                    end else begin
                        // Invalidate first so an aborted refill never leaves a stale line visible.
                        r_valid[w_index] <= 1'b0;
                        r_mem_req_valid  <= 1'b1;
                        r_mem_req_write  <= 1'b0;
                        r_mem_req_addr   <= {w_tag, w_index, {OFFSET_W{1'b0}}};
                        r_mem_req_wdata  <= '0;
                        r_state          <= FILL_REQ;
                    end
                end
                FILL_REQ: begin
                    if (mem_req_ready) begin
                        r_mem_req_valid <= 1'b0;
                        r_beat_cnt      <= '0;
                        r_state         <= FILL;
                    end
                end
                FILL: begin
                    if (mem_resp_valid) begin
                        r_beat_cnt <= r_beat_cnt + OFFSET_W'(1);
                        if (r_beat_cnt == w_offset) begin
                            r_resp_rdata <= mem_resp_rdata;
                        end
                        if (w_last_beat) begin
                            r_valid[w_index] <= 1'b1;
                            r_resp_valid     <= 1'b1;
                            r_state          <= RESP;
                        end
                    end
                end
                WR_MEM: begin
                    if (mem_req_ready) begin
                        r_mem_req_valid <= 1'b0;
                        r_resp_valid    <= 1'b1;
                        r_state         <= RESP;
                    end
                end
                RESP: begin
                    r_resp_valid <= 1'b0;
                    r_req_ready  <= 1'b1;
                    r_state      <= IDLE;
                end
                default: begin
                    r_state     <= IDLE;
                    r_req_ready <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready     = r_req_ready;
    assign resp_valid    = r_resp_valid;
    assign resp_rdata    = r_resp_rdata;
    assign resp_hit      = r_resp_hit;
    assign mem_req_valid = r_mem_req_valid;
    assign mem_req_write = r_mem_req_write;
    assign mem_req_addr  = r_mem_req_addr;
    assign mem_req_wdata = r_mem_req_wdata;
    assign hit_count     = r_hit_count;
    assign miss_count    = r_miss_count;

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Scoreboard bench for dm_cache_ctrl: expected responses are queued at issue
// time and checked when resp_valid fires; the memory side is driven by tasks.
module tb_dm_cache_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_hit;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic        mem_req_write;
    logic [31:0] mem_req_addr;
    logic [31:0] mem_req_wdata;
    logic        mem_resp_valid = 1'b0;
    logic [31:0] mem_resp_rdata = '0;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    typedef struct {
        logic [31:0] rdata;
        logic        hit;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    dm_cache_ctrl #(
        .ADDR_W   (32),
        .DATA_W   (32),
        .INDEX_W  (8),
        .OFFSET_W (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_write      (req_write),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_rdata     (resp_rdata),
        .resp_hit       (resp_hit),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_write  (mem_req_write),
        .mem_req_addr   (mem_req_addr),
        .mem_req_wdata  (mem_req_wdata),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_rdata (mem_resp_rdata),
        .hit_count      (hit_count),
        .miss_count     (miss_count)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input logic exp_hit);
        total++;
        if (req_ready !== 1'b1) begin
            bad++;
            $display("FAIL req_ready_idle addr=%h got=%b exp=1", addr, req_ready);
        end
        sb.push_back('{rdata: exp_rdata, hit: exp_hit});
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wdata;
        tick();
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = $urandom;
        req_wdata = $urandom;
    endtask

    task automatic wait_resp(input string name, input int exp_lat);
        int   n = 0;
        exp_t e;
        while (resp_valid !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        total++;
        if (resp_valid !== 1'b1) begin
            bad++;
            $display("FAIL %s resp_timeout got=no_resp exp=resp_valid", name);
            if (sb.size() > 0) void'(sb.pop_front());
            return;
        end
        if (sb.size() == 0) begin
            bad++;
            $display("FAIL %s unexpected_resp got=resp exp=none", name);
            return;
        end
        e = sb.pop_front();
        if (exp_lat >= 0) begin
            total++;
            if (n != exp_lat) begin
                bad++;
                $display("FAIL %s latency got=%0d exp=%0d", name, n, exp_lat);
            end
        end
        total++;
        if (resp_rdata !== e.rdata) begin
            bad++;
            $display("FAIL %s resp_rdata got=%h exp=%h", name, resp_rdata, e.rdata);
        end
        total++;
        if (resp_hit !== e.hit) begin
            bad++;
            $display("FAIL %s resp_hit got=%b exp=%b", name, resp_hit, e.hit);
        end
        tick();
        total++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            bad++;
            $display("FAIL %s resp_pulse got=valid%b_ready%b exp=valid0_ready1", name, resp_valid, req_ready);
        end
    endtask

    task automatic wait_mem_req(input string name, output logic ok);
        int n = 0;
        while (mem_req_valid !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        total++;
        ok = (mem_req_valid === 1'b1);
        if (!ok) begin
            bad++;
            $display("FAIL %s mem_req_timeout got=%b exp=1", name, mem_req_valid);
        end
    endtask

    task automatic serve_fill(input string name, input logic [31:0] exp_addr, input logic [31:0] base,
                              input int nbeats, input int stall, input int gap_at);
        logic ok;
        wait_mem_req(name, ok);
        if (!ok) return;
        total++;
        if (mem_req_write !== 1'b0 || mem_req_addr !== exp_addr) begin
            bad++;
            $display("FAIL %s fill_req got=w%b_%h exp=w0_%h", name, mem_req_write, mem_req_addr, exp_addr);
        end
        for (int s = 0; s < stall; s++) begin
            mem_resp_valid = 1'b1;
            mem_resp_rdata = 32'hBAD0_0000 + 32'(s);
            tick();
            total++;
            if (mem_req_valid !== 1'b1 || mem_req_write !== 1'b0 || mem_req_addr !== exp_addr) begin
                bad++;
                $display("FAIL %s fill_req_hold got=v%b_w%b_%h exp=v1_w0_%h", name,
                         mem_req_valid, mem_req_write, mem_req_addr, exp_addr);
            end
        end
        mem_resp_valid = 1'b0;
        mem_req_ready  = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        total++;
        if (mem_req_valid !== 1'b0) begin
            bad++;
            $display("FAIL %s fill_req_drop got=%b exp=0", name, mem_req_valid);
        end
        for (int i = 0; i < nbeats; i++) begin
            if (i == gap_at) begin
                mem_resp_valid = 1'b0;
                tick();
            end
            mem_resp_valid = 1'b1;
            mem_resp_rdata = base + 32'(i);
            tick();
        end
        mem_resp_valid = 1'b0;
        mem_resp_rdata = $urandom;
    endtask

    task automatic serve_write(input string name, input logic [31:0] exp_addr, input logic [31:0] exp_wdata,
                               input int stall);
        logic ok;
        wait_mem_req(name, ok);
        if (!ok) return;
        total++;
        if (mem_req_write !== 1'b1 || mem_req_addr !== exp_addr || mem_req_wdata !== exp_wdata) begin
            bad++;
            $display("FAIL %s wr_req got=w%b_%h_%h exp=w1_%h_%h", name, mem_req_write,
                     mem_req_addr, mem_req_wdata, exp_addr, exp_wdata);
        end
        for (int s = 0; s < stall; s++) begin
            tick();
            total++;
            if (mem_req_valid !== 1'b1 || mem_req_addr !== exp_addr || mem_req_wdata !== exp_wdata) begin
                bad++;
                $display("FAIL %s wr_req_hold got=v%b_%h_%h exp=v1_%h_%h", name, mem_req_valid,
                         mem_req_addr, mem_req_wdata, exp_addr, exp_wdata);
            end
        end
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
    endtask

    task automatic check_counts(input string name, input logic [31:0] exp_hits, input logic [31:0] exp_miss);
        total++;
        if (hit_count !== exp_hits) begin
            bad++;
            $display("FAIL %s hit_count got=%0d exp=%0d", name, hit_count, exp_hits);
        end
        total++;
        if (miss_count !== exp_miss) begin
            bad++;
            $display("FAIL %s miss_count got=%0d exp=%0d", name, miss_count, exp_miss);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        total++;
        if (req_ready !== 1'b1) begin bad++; $display("FAIL reset req_ready got=%b exp=1", req_ready); end
        total++;
        if (resp_valid !== 1'b0) begin bad++; $display("FAIL reset resp_valid got=%b exp=0", resp_valid); end
        total++;
        if (resp_rdata !== 32'h0) begin bad++; $display("FAIL reset resp_rdata got=%h exp=0", resp_rdata); end
        total++;
        if (resp_hit !== 1'b0) begin bad++; $display("FAIL reset resp_hit got=%b exp=0", resp_hit); end
        total++;
        if (mem_req_valid !== 1'b0) begin bad++; $display("FAIL reset mem_req_valid got=%b exp=0", mem_req_valid); end
        check_counts("reset", 32'd0, 32'd0);
    endtask

    task automatic test_load_miss;
        issue(1'b0, 32'h0000_0123, 32'h0, 32'h0000_00A3, 1'b0);
        serve_fill("load_miss", 32'h0000_0120, 32'h0000_00A0, 16, 2, -1);
        wait_resp("load_miss", 0);
        check_counts("load_miss", 32'd0, 32'd1);
    endtask

    task automatic test_load_hit;
        // Stray refill beats while idle must not disturb the cached line.
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 32'h5555_5555;
        tick();
        tick();
        mem_resp_valid = 1'b0;
        issue(1'b0, 32'h0000_0123, 32'h0, 32'h0000_00A3, 1'b1);
        wait_resp("load_hit", 1);
        check_counts("load_hit", 32'd1, 32'd1);
    endtask

    task automatic test_conflict;
        issue(1'b0, 32'h0000_1123, 32'h0, 32'h0000_00B3, 1'b0);
        serve_fill("conflict_new", 32'h0000_1120, 32'h0000_00B0, 16, 0, 9);
        wait_resp("conflict_new", 0);
        issue(1'b0, 32'h0000_0123, 32'h0, 32'h0000_00A3, 1'b0);
        serve_fill("conflict_old", 32'h0000_0120, 32'h0000_00A0, 16, 1, -1);
        wait_resp("conflict_old", 0);
        check_counts("conflict", 32'd1, 32'd3);
    endtask

    task automatic test_store_hit;
        issue(1'b1, 32'h0000_0125, 32'hDEAD_BEEF, 32'h0, 1'b1);
        serve_write("store_hit", 32'h0000_0125, 32'hDEAD_BEEF, 2);
        wait_resp("store_hit", 0);
        issue(1'b0, 32'h0000_0125, 32'h0, 32'hDEAD_BEEF, 1'b1);
        wait_resp("store_hit_load", 1);
        issue(1'b0, 32'h0000_0124, 32'h0, 32'h0000_00A4, 1'b1);
        wait_resp("store_hit_neighbour", 1);
        check_counts("store_hit", 32'd4, 32'd3);
    endtask

    task automatic test_store_miss;
        issue(1'b1, 32'h0000_2250, 32'h1234_5678, 32'h0, 1'b0);
        serve_write("store_miss", 32'h0000_2250, 32'h1234_5678, 0);
        wait_resp("store_miss", 0);
        issue(1'b0, 32'h0000_2257, 32'h0, 32'h0000_00C7, 1'b0);
        serve_fill("store_miss_load", 32'h0000_2250, 32'h0000_00C0, 16, 0, 3);
        wait_resp("store_miss_load", 0);
        issue(1'b0, 32'h0000_2250, 32'h0, 32'h0000_00C0, 1'b1);
        wait_resp("store_miss_word0", 1);
        check_counts("store_miss", 32'd5, 32'd5);
    endtask

    task automatic test_reset_refill;
        int stray = 0;
        issue(1'b0, 32'h0000_0345, 32'h0, 32'h0000_00D5, 1'b0);
        serve_fill("abort", 32'h0000_0340, 32'h0000_00D0, 8, 0, -1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        void'(sb.pop_back());
        total++;
        if (req_ready !== 1'b1 || mem_req_valid !== 1'b0) begin
            bad++;
            $display("FAIL abort_state got=ready%b_memv%b exp=ready1_memv0", req_ready, mem_req_valid);
        end
        check_counts("abort", 32'd0, 32'd0);
        for (int i = 0; i < 5; i++) begin
            if (resp_valid !== 1'b0) stray++;
            tick();
        end
        total++;
        if (stray != 0) begin
            bad++;
            $display("FAIL abort_no_resp got=%0d exp=0", stray);
        end
        issue(1'b0, 32'h0000_0345, 32'h0, 32'h0000_00E5, 1'b0);
        serve_fill("refill", 32'h0000_0340, 32'h0000_00E0, 16, 2, 12);
        wait_resp("refill", 0);
        issue(1'b0, 32'h0000_034F, 32'h0, 32'h0000_00EF, 1'b1);
        wait_resp("refill_last_word", 1);
        issue(1'b0, 32'h0000_0340, 32'h0, 32'h0000_00E0, 1'b1);
        wait_resp("refill_first_word", 1);
        check_counts("refill", 32'd2, 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_load_miss();
        test_load_hit();
        test_conflict();
        test_store_hit();
        test_store_miss();
        test_reset_refill();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain got=%0d exp=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
